// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and hex glyph table for the seven-segment scan driver
package ssd_pkg;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [7:0] ANODES_OFF = 8'hFF;

    // Active-low {a,b,c,d,e,f,g}; letters follow the usual A b C d E F shapes.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// rtl/ssd_hex_decoder.sv - combinational nibble plus decimal point to active-low cathode byte
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] cathode
);

    assign cathode = {hex_to_seg(nibble), ~dp};

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - tear-free multiplexed seven-segment scan with blanking, blink and guard
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV_BITS  = 18,
    parameter int BLINK_DIV_BITS = 26,
    parameter int GUARD_CYCLES   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    lz_blank,
    input  logic                    update,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [7:0]              cathodes,
    output logic                    frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_DIV_BITS:0] GUARD_LIM = (SCAN_DIV_BITS + 1)'(GUARD_CYCLES);

    logic [SCAN_DIV_BITS-1:0]  prescaler;
    logic [IDX_W-1:0]          idx;
    logic [BLINK_DIV_BITS-1:0] blink_cnt;
    logic                      blink_phase;
    logic                      pending;
    logic                      fs_arm;

    logic [4*NUM_DIGITS-1:0] shadow_value, disp_value;
    logic [NUM_DIGITS-1:0]   shadow_dp, shadow_en, shadow_blink;
    logic [NUM_DIGITS-1:0]   disp_dp, disp_en, disp_blink;

    logic                  scan_tc, frame_end, in_guard, blanked, upper_zero;
    logic [NUM_DIGITS-1:0] lz_mask, digit_sel, anodes_nxt;
    logic [3:0]            cur_nibble;
    logic [7:0]            glyph_cath, cathodes_nxt;

    assign scan_tc   = &prescaler;
    assign frame_end = scan_tc && (idx == LAST_IDX);

    // A digit is a leading zero when it and every more significant display nibble are zero.
    always_comb begin
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (disp_value[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_blank & upper_zero & (i != 0);
        end
    end

    assign cur_nibble = disp_value[{idx, 2'b00} +: 4];
    assign blanked    = ~disp_en[idx] | (disp_blink[idx] & blink_phase) | lz_mask[idx];
    assign in_guard   = {1'b0, prescaler} < GUARD_LIM;
    assign digit_sel  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);

    ssd_hex_decoder u_hex_decoder (
        .nibble  (cur_nibble),
        .dp      (disp_dp[idx]),
        .cathode (glyph_cath)
    );

    assign anodes_nxt   = (blanked || in_guard) ? ANODES_OFF[NUM_DIGITS-1:0] : digit_sel;
    assign cathodes_nxt = blanked ? SEG_BLANK : glyph_cath;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler    <= '0;
            idx          <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            pending      <= 1'b0;
            fs_arm       <= 1'b0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_en    <= '0;
            shadow_blink <= '0;
            disp_value   <= '0;
            disp_dp      <= '0;
            disp_en      <= '0;
            disp_blink   <= '0;
            anodes       <= ANODES_OFF[NUM_DIGITS-1:0];
            cathodes     <= SEG_BLANK;
            frame_start  <= 1'b0;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (scan_tc) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt) begin
                blink_phase <= ~blink_phase;
            end
            // Copy uses the pre-update shadow so a frame never mixes old and new digits.
            if (frame_end && pending) begin
                disp_value <= shadow_value;
                disp_dp    <= shadow_dp;
                disp_en    <= shadow_en;
                disp_blink <= shadow_blink;
            end
            if (update) begin
                shadow_value <= value;
                shadow_dp    <= dp_in;
                shadow_en    <= digit_en;
                shadow_blink <= blink_en;
            end
            pending     <= update | (pending & ~frame_end);
            fs_arm      <= frame_end;
            frame_start <= fs_arm;
            anodes      <= anodes_nxt;
            cathodes    <= cathodes_nxt;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - randomized self-checking bench with a frame-level display model
module tb_ssd_scan_driver;

    localparam int ND = 4;
    localparam int SD = 3;
    localparam int BD = 6;
    localparam int GC = 1;
    localparam int SLOT  = 1 << SD;
    localparam int FRAME = SLOT * ND;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0, digit_en = '0, blink_en = '0;
    logic        lz_blank = 1'b0, update = 1'b0;
    logic [3:0]  anodes;
    logic [7:0]  cathodes;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV_BITS(SD), .BLINK_DIV_BITS(BD), .GUARD_CYCLES(GC)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .blink_en(blink_en), .lz_blank(lz_blank), .update(update),
        .anodes(anodes), .cathodes(cathodes), .frame_start(frame_start)
    );

    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] g [16];
        g = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
        return g[h];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Model: n counts clock edges since reset release; the shown content is whatever the
    // latest update held strictly before the most recent frame boundary.
    int          n = 0;
    logic [15:0] lat_v = '0, shw_v = '0;
    logic [3:0]  lat_dp = '0, lat_en = '0, lat_bl = '0;
    logic [3:0]  shw_dp = '0, shw_en = '0, shw_bl = '0;
    logic [3:0]  exp_an;
    logic [7:0]  exp_ca;
    logic        exp_fs;
    bit          check_en = 0;
    int          m_dig, m_pos, m_ph;
    bit          m_blank;

    always @(posedge clk) begin
        if (rst) begin
            exp_an = 4'hF; exp_ca = 8'hFF; exp_fs = 1'b0; n = 0;
            lat_v = '0; lat_dp = '0; lat_en = '0; lat_bl = '0;
            shw_v = '0; shw_dp = '0; shw_en = '0; shw_bl = '0;
        end else begin
            m_dig = (n / SLOT) % ND;
            m_pos = n % SLOT;
            m_ph  = (n / (1 << BD)) % 2;
            m_blank = !shw_en[m_dig] || (shw_bl[m_dig] && m_ph == 1) ||
                      (lz_blank && m_dig > 0 && (shw_v >> (4 * m_dig)) == 0);
            if (m_blank) begin
                exp_an = 4'hF;
                exp_ca = 8'hFF;
            end else begin
                exp_an = (m_pos < GC) ? 4'hF : ~(4'(1) << m_dig);
                exp_ca = {glyph(4'((shw_v >> (4 * m_dig)) & 16'hF)), ~shw_dp[m_dig]};
            end
            exp_fs = (n % FRAME == 0) && (n > 0);
            if (n % FRAME == FRAME - 1) begin
                shw_v = lat_v; shw_dp = lat_dp; shw_en = lat_en; shw_bl = lat_bl;
            end
            if (update) begin
                lat_v = value; lat_dp = dp_in; lat_en = digit_en; lat_bl = blink_en;
            end
            n++;
        end
        check_en = 1;
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_anodes", anodes, exp_an);
            check("model_cathodes", cathodes, exp_ca);
            check("model_frame_start", frame_start, exp_fs);
        end
    end

    task automatic do_update(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                             input logic [3:0] bl);
        @(negedge clk);
        value = v; dp_in = dp; digit_en = en; blink_en = bl; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_fs();
        for (int c = 0; c < 4 * FRAME; c++) begin
            @(negedge clk);
            if (frame_start === 1'b1) return;
        end
        check("frame_start_timeout", 32'd0, 32'd1);
    endtask

    // cs/as hold the expected per-slot cathodes/anodes, slot 0 in the low bits.
    task automatic pin_frame(input string tag, input logic [31:0] cs, input logic [15:0] as);
        wait_fs();
        for (int s = 0; s < ND; s++) begin
            check({tag, "_guard_an"}, anodes, 4'hF);
            check({tag, "_guard_ca"}, cathodes, cs[8*s +: 8]);
            @(negedge clk);
            check({tag, "_an"}, anodes, as[4*s +: 4]);
            check({tag, "_ca"}, cathodes, cs[8*s +: 8]);
            repeat (SLOT - 1) @(negedge clk);
        end
    endtask

    task automatic measure_fs(input string tag, input int req);
        int c;
        c = 0;
        for (int k = 1; k <= 3 * FRAME; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                c = k;
                break;
            end
        end
        check(tag, c, req);
    endtask

    task automatic wait_phase(input int pos);
        for (int c = 0; c < 2 * FRAME && (n % FRAME) != pos; c++) @(negedge clk);
        check("phase_align", n % FRAME, pos);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_anodes", anodes, 4'hF);
        check("reset_cathodes", cathodes, 8'hFF);
        check("reset_frame_start", frame_start, 1'b0);
        rst = 1'b0;
        measure_fs("first_fs_delay", 33);
        measure_fs("fs_period", 32);

        do_update(16'h12A0, 4'b0010, 4'hF, 4'h0);
        pin_frame("hex_frame", 32'h9F251003, 16'h7BDE);

        lz_blank = 1'b1;
        do_update(16'h0005, 4'h0, 4'hF, 4'h0);
        pin_frame("lz_five", 32'hFFFFFF49, 16'hFFFE);
        do_update(16'h0000, 4'h0, 4'hF, 4'h0);
        pin_frame("lz_zero", 32'hFFFFFF03, 16'hFFFE);
        lz_blank = 1'b0;

        do_update(16'h1234, 4'h0, 4'hF, 4'b0001);
        repeat (300) @(negedge clk);

        do_update(16'h3333, 4'h0, 4'hF, 4'h0);
        wait_fs();
        wait_fs();
        wait_phase(FRAME - 1);
        value = 16'h8888; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        pin_frame("boundary_old", 32'h0D0D0D0D, 16'h7BDE);
        pin_frame("boundary_new", 32'h01010101, 16'h7BDE);

        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            value = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'($urandom);
            blink_en = 4'($urandom); lz_blank = 1'($urandom);
            update = ($urandom_range(0, 2) == 0);
            if (it % 10 == 0) value = 16'($urandom_range(0, 255));
            repeat ($urandom_range(1, 50)) begin
                @(negedge clk);
                update = (it % 7 == 3) ? 1'b1 : 1'b0;
            end
            update = 1'b0;
        end

        lz_blank = 1'b0;
        do_update(16'hFFFF, 4'hF, 4'hF, 4'h0);
        wait_fs();
        wait_phase(2 * SLOT + 4);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_anodes", anodes, 4'hF);
        check("midreset_cathodes", cathodes, 8'hFF);
        check("midreset_frame_start", frame_start, 1'b0);
        rst = 1'b0;
        measure_fs("restart_fs_delay", 33);
        @(negedge clk);
        check("cleared_display_dark", {anodes, cathodes}, 12'hFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
